// File: rtl/controle_turno_if.sv
// Shot/checker/status bundle of the battleship turn controller.
//   master : UI + collision-checker side (drives shot request, col_ready/col_hit)
//   slave  : controle_turno (drives handshake, checker request and game status)
interface controle_turno_if;
  localparam int unsigned COORD_W = 4;
  localparam int unsigned HITS_W  = 5;

  logic               shot_valid;
  logic [COORD_W-1:0] shot_x;
  logic [COORD_W-1:0] shot_y;
  logic               shot_ready;
  logic               col_enable;
  logic [COORD_W-1:0] col_x;
  logic [COORD_W-1:0] col_y;
  logic               col_jogador;
  logic               col_ready;
  logic               col_hit;
  logic               turno;
  logic [HITS_W-1:0]  hits_p1;
  logic [HITS_W-1:0]  hits_p2;
  logic               result_valid;
  logic               result_hit;
  logic               erro;
  logic               fim_jogo;
  logic               vencedor;

  modport master (
    output shot_valid, shot_x, shot_y, col_ready, col_hit,
    input  shot_ready, col_enable, col_x, col_y, col_jogador, turno,
           hits_p1, hits_p2, result_valid, result_hit, erro, fim_jogo, vencedor
  );

  modport slave (
    input  shot_valid, shot_x, shot_y, col_ready, col_hit,
    output shot_ready, col_enable, col_x, col_y, col_jogador, turno,
           hits_p1, hits_p2, result_valid, result_hit, erro, fim_jogo, vencedor
  );
endinterface

// File: rtl/controle_turno.sv
// Turn controller for a two-player battleship game: accepts one shot per turn,
// runs the external collision check, scores hits, switches turns and detects
// the end of the game.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : controle_turno_if.slave (shot handshake, checker request/response,
//              turn, score counters, result pulse, timeout flag, game-over status)
// All outputs are registered; output flops are loaded from the next state.
module controle_turno #(
  parameter int unsigned TOTAL_PECAS = 17,
  parameter int unsigned TIMEOUT     = 31
) (
  input  logic           clk,
  input  logic           rst,
  controle_turno_if.slave bus
);

  localparam int unsigned COORD_W = 4;
  localparam int unsigned HITS_W  = 5;
  localparam int unsigned CNT_W   = 6;

  typedef enum logic [1:0] {IDLE, CHECK, RESOLVE, GAME_OVER} state_e;

  state_e             state_q, state_d;
  logic [COORD_W-1:0] col_x_q, col_x_d, col_y_q, col_y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [HITS_W-1:0]  hits_p1_q, hits_p1_d, hits_p2_q, hits_p2_d;
  logic               hit_seen_q, hit_seen_d;
  logic               turno_q, turno_d;
  logic               erro_q, erro_d;
  logic               vencedor_q, vencedor_d;
  logic               shot_ready_q, shot_ready_d;
  logic               col_enable_q, col_enable_d;
  logic               col_jogador_q, col_jogador_d;
  logic               result_valid_q, result_valid_d;
  logic               result_hit_q, result_hit_d;
  logic               fim_jogo_q, fim_jogo_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      col_x_q        <= '0;
      col_y_q        <= '0;
      cnt_q          <= '0;
      hits_p1_q      <= '0;
      hits_p2_q      <= '0;
      hit_seen_q     <= 1'b0;
      turno_q        <= 1'b0;
      erro_q         <= 1'b0;
      vencedor_q     <= 1'b0;
      shot_ready_q   <= 1'b1;
      col_enable_q   <= 1'b0;
      col_jogador_q  <= 1'b0;
      result_valid_q <= 1'b0;
      result_hit_q   <= 1'b0;
      fim_jogo_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      col_x_q        <= col_x_d;
      col_y_q        <= col_y_d;
      cnt_q          <= cnt_d;
      hits_p1_q      <= hits_p1_d;
      hits_p2_q      <= hits_p2_d;
      hit_seen_q     <= hit_seen_d;
      turno_q        <= turno_d;
      erro_q         <= erro_d;
      vencedor_q     <= vencedor_d;
      shot_ready_q   <= shot_ready_d;
      col_enable_q   <= col_enable_d;
      col_jogador_q  <= col_jogador_d;
      result_valid_q <= result_valid_d;
      result_hit_q   <= result_hit_d;
      fim_jogo_q     <= fim_jogo_d;
    end
  end

  // Next state and datapath updates
  always_comb begin
    state_d    = state_q;
    col_x_d    = col_x_q;
    col_y_d    = col_y_q;
    cnt_d      = cnt_q;
    hits_p1_d  = hits_p1_q;
    hits_p2_d  = hits_p2_q;
    hit_seen_d = hit_seen_q;
    turno_d    = turno_q;
    erro_d     = erro_q;
    vencedor_d = vencedor_q;
    unique case (state_q)
      IDLE: begin
        if (bus.shot_valid) begin
          col_x_d    = bus.shot_x;
          col_y_d    = bus.shot_y;
          hit_seen_d = 1'b0;
          cnt_d      = '0;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.col_hit) hit_seen_d = 1'b1;
        if (bus.col_ready) begin
          state_d = RESOLVE;
        end else if (cnt_d == CNT_W'(TIMEOUT)) begin
          // Aborted check always scores as a miss, even if col_hit was seen
          erro_d     = 1'b1;
          hit_seen_d = 1'b0;
          state_d    = RESOLVE;
        end
      end
      RESOLVE: begin
        state_d = IDLE;
        if (hit_seen_q) begin
          // Shooter keeps the turn after a hit; saturate at TOTAL_PECAS
          if (!turno_q) begin
            if (hits_p1_q < HITS_W'(TOTAL_PECAS)) hits_p1_d = hits_p1_q + HITS_W'(1);
            if (hits_p1_d == HITS_W'(TOTAL_PECAS)) state_d = GAME_OVER;
          end else begin
            if (hits_p2_q < HITS_W'(TOTAL_PECAS)) hits_p2_d = hits_p2_q + HITS_W'(1);
            if (hits_p2_d == HITS_W'(TOTAL_PECAS)) state_d = GAME_OVER;
          end
          if (state_d == GAME_OVER) vencedor_d = turno_q;
        end else begin
          turno_d = ~turno_q;
        end
      end
      GAME_OVER: state_d = GAME_OVER;
      default:   state_d = IDLE;
    endcase
  end

  // Output flop inputs decoded from the next state
  always_comb begin
    shot_ready_d   = (state_d == IDLE);
    col_enable_d   = (state_d == CHECK);
    col_jogador_d  = turno_d;
    result_valid_d = (state_d == RESOLVE);
    result_hit_d   = (state_d == RESOLVE) && hit_seen_d;
    fim_jogo_d     = (state_d == GAME_OVER);
  end

  assign bus.shot_ready   = shot_ready_q;
  assign bus.col_enable   = col_enable_q;
  assign bus.col_x        = col_x_q;
  assign bus.col_y        = col_y_q;
  assign bus.col_jogador  = col_jogador_q;
  assign bus.turno        = turno_q;
  assign bus.hits_p1      = hits_p1_q;
  assign bus.hits_p2      = hits_p2_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result_hit   = result_hit_q;
  assign bus.erro         = erro_q;
  assign bus.fim_jogo     = fim_jogo_q;
  assign bus.vencedor     = vencedor_q;

endmodule

// File: tb/tb_controle_turno.sv
// Self-checking bench for controle_turno: a scripted collision checker answers
// each shot, expected results are queued at shot acceptance and compared when
// the result pulse appears; a small game model tracks turn, scores and flags.
module tb_controle_turno;

  localparam int unsigned TOTAL = 17;
  localparam int unsigned TMO   = 31;

  typedef struct {
    logic       hit;
    int         lat;
    logic       jog;
    logic [3:0] x;
    logic [3:0] y;
    bit         timeout;
  } exp_t;

  logic clk;
  logic rst;
  controle_turno_if bus ();

  controle_turno #(.TOTAL_PECAS(TOTAL), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb_q[$];

  logic m_turno;
  int   m_hits[2];
  logic m_erro;
  logic m_over;
  logic m_venc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_turno = 1'b0; m_hits[0] = 0; m_hits[1] = 0;
    m_erro = 1'b0; m_over = 1'b0; m_venc = 1'b0;
    sb_q.delete();
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_hits_p1"},  32'(bus.hits_p1), 32'(m_hits[0]));
    check_eq({tag, "_hits_p2"},  32'(bus.hits_p2), 32'(m_hits[1]));
    check_eq({tag, "_turno"},    32'(bus.turno),   32'(m_turno));
    check_eq({tag, "_erro"},     32'(bus.erro),    32'(m_erro));
    check_eq({tag, "_fim_jogo"}, 32'(bus.fim_jogo), 32'(m_over));
    check_eq({tag, "_vencedor"}, 32'(bus.vencedor), 32'(m_venc));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_shot_ready"},   32'(bus.shot_ready), 32'(1));
    check_eq({tag, "_col_enable"},   32'(bus.col_enable), 32'(0));
    check_eq({tag, "_col_x"},        32'(bus.col_x), 32'(0));
    check_eq({tag, "_col_y"},        32'(bus.col_y), 32'(0));
    check_eq({tag, "_col_jogador"},  32'(bus.col_jogador), 32'(0));
    check_eq({tag, "_result_valid"}, 32'(bus.result_valid), 32'(0));
    check_eq({tag, "_result_hit"},   32'(bus.result_hit), 32'(0));
    check_status(tag);
  endtask

  // Called at a negedge; returns at the negedge after RESOLVE (IDLE or GAME_OVER).
  // ready_cyc = 0 means the checker never answers (timeout path).
  task automatic do_shot(input logic [3:0] x, input logic [3:0] y,
                         input int hit_cyc, input int ready_cyc, input bit hold);
    exp_t e;
    exp_t r;
    int   guard;
    int   lat;
    int   ncheck;
    bit   got;
    guard = 0;
    while (bus.shot_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (bus.shot_ready !== 1'b1) begin
      check_eq("shot_ready_wait", 32'(bus.shot_ready), 32'(1));
      return;
    end
    bus.shot_x = x;
    bus.shot_y = y;
    bus.shot_valid = 1'b1;
    e.x = x; e.y = y; e.jog = m_turno;
    e.timeout = (ready_cyc == 0);
    e.hit = !e.timeout && hit_cyc != 0 && hit_cyc <= ready_cyc;
    e.lat = (e.timeout ? int'(TMO) : ready_cyc) + 2;
    sb_q.push_back(e);
    lat = 1; ncheck = 0; got = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      lat++;
      if (hold) begin
        bus.shot_x = 4'($urandom);
        bus.shot_y = 4'($urandom);
      end else begin
        bus.shot_valid = 1'b0;
      end
      if (bus.col_enable === 1'b1) begin
        ncheck++;
        check_eq("col_x_stable", 32'(bus.col_x), 32'(e.x));
        check_eq("col_y_stable", 32'(bus.col_y), 32'(e.y));
        check_eq("col_jogador", 32'(bus.col_jogador), 32'(e.jog));
        check_eq("shot_ready_in_check", 32'(bus.shot_ready), 32'(0));
        bus.col_hit   = (ncheck == hit_cyc);
        bus.col_ready = (ncheck == ready_cyc);
      end else begin
        bus.col_hit   = 1'b0;
        bus.col_ready = 1'b0;
      end
      if (bus.result_valid === 1'b1) begin
        got = 1;
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", 32'(0), 32'(1));
        end else begin
          r = sb_q.pop_front();
          if (r.timeout) m_erro = 1'b1;
          check_eq("result_hit", 32'(bus.result_hit), 32'(r.hit));
          check_eq("latency", 32'(lat), 32'(r.lat));
          check_eq("check_cycles", 32'(ncheck), 32'(r.lat - 2));
          check_eq("resolve_col_enable", 32'(bus.col_enable), 32'(0));
          check_eq("resolve_shot_ready", 32'(bus.shot_ready), 32'(0));
          check_eq("resolve_erro", 32'(bus.erro), 32'(m_erro));
          if (r.hit) begin
            m_hits[m_turno]++;
            if (m_hits[m_turno] == int'(TOTAL)) begin
              m_over = 1'b1;
              m_venc = m_turno;
            end
          end else begin
            m_turno = ~m_turno;
          end
        end
      end
    end
    if (!got) begin
      check_eq("result_never_seen", 32'(0), 32'(1));
      return;
    end
    @(negedge clk);
    check_eq("post_result_valid", 32'(bus.result_valid), 32'(0));
    check_eq("post_col_enable", 32'(bus.col_enable), 32'(0));
    check_eq("post_shot_ready", 32'(bus.shot_ready), 32'(!m_over));
    check_status("post");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    rst = 1'b1;
    bus.shot_valid = 1'b0;
    bus.shot_x = '0;
    bus.shot_y = '0;
    bus.col_ready = 1'b0;
    bus.col_hit = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // P1 hit: col_hit on check cycle 2, answer on cycle 4
    do_shot(4'd3, 4'd5, 2, 4, 1'b0);
    // P1 clean miss answered immediately
    do_shot(4'd7, 4'd1, 0, 1, 1'b0);
    // P2 checker never answers: timeout, hit ignored
    do_shot(4'd9, 4'd12, 5, 0, 1'b0);
    // shot_valid held high across two shots; hit on the answer edge, then miss
    do_shot(4'd2, 4'd2, 3, 3, 1'b1);
    do_shot(4'd15, 4'd0, 0, 2, 1'b1);
    bus.shot_valid = 1'b0;

    // Reset in the middle of a check, colliding with shot_valid and col_ready
    do_shot_reset_mid_check();

    // Drive P2 to the winning hit
    do_shot(4'd1, 4'd1, 0, 1, 1'b0);
    for (int i = 0; i < int'(TOTAL) - 1; i++) begin
      rc = $urandom_range(1, 4);
      do_shot(4'($urandom), 4'($urandom), $urandom_range(1, rc), rc, 1'b0);
    end
    check_eq("pre_win_hits_p2", 32'(bus.hits_p2), 32'(TOTAL - 1));
    do_shot(4'd8, 4'd4, 1, 2, 1'b0);
    check_eq("win_hits_p2", 32'(bus.hits_p2), 32'(TOTAL));
    check_eq("win_vencedor", 32'(bus.vencedor), 32'(1));

    // Game over: further shots ignored, everything frozen
    bus.shot_valid = 1'b1;
    bus.shot_x = 4'd6;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("go_shot_ready", 32'(bus.shot_ready), 32'(0));
      check_eq("go_col_enable", 32'(bus.col_enable), 32'(0));
      check_eq("go_result_valid", 32'(bus.result_valid), 32'(0));
      check_status("go");
    end
    bus.shot_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  task automatic do_shot_reset_mid_check();
    int guard;
    guard = 0;
    while (bus.shot_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bus.shot_x = 4'd11;
    bus.shot_y = 4'd13;
    bus.shot_valid = 1'b1;
    @(negedge clk);
    bus.shot_valid = 1'b0;
    check_eq("rstmid_col_enable_c1", 32'(bus.col_enable), 32'(1));
    @(negedge clk);
    check_eq("rstmid_col_enable_c2", 32'(bus.col_enable), 32'(1));
    rst = 1'b1;
    bus.shot_valid = 1'b1;
    bus.col_ready = 1'b1;
    bus.col_hit = 1'b1;
    @(negedge clk);
    model_reset();
    check_reset_outputs("rstmid");
    rst = 1'b0;
    bus.shot_valid = 1'b0;
    bus.col_ready = 1'b0;
    bus.col_hit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rstmid_no_result", 32'(bus.result_valid), 32'(0));
      check_eq("rstmid_idle", 32'(bus.shot_ready), 32'(1));
      check_status("rstmid_after");
    end
  endtask

endmodule

// File: doc/controle_turno.md
CONTROLE_TURNO -- requirements
Module: controle_turno

Interface
REQ-001 SHALL have parameter TOTAL_PECAS, default 17, the number of ship cells per player; reaching it ends the game.
REQ-002 SHALL have parameter TIMEOUT, default 31, the maximum number of cycles in CHECK before the check is aborted.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port shot_valid, input, 1 bit: shot request from the input/UI logic.
REQ-006 SHALL have port shot_x / shot_y, input, 4 bits each: shot coordinates.
REQ-007 SHALL have port shot_ready, output, 1 bit: the controller can accept a shot.
REQ-008 SHALL have port col_enable, output, 1 bit: enable to the collision checker.
REQ-009 SHALL have port col_x / col_y, output, 4 bits each: latched coordinates to the checker.
REQ-010 SHALL have port col_jogador, output, 1 bit: shooting player to the checker (0 = P1, 1 = P2).
REQ-011 SHALL have port col_ready / col_hit, input, 1 bit each: checker done / checker hit.
REQ-012 SHALL have port turno, output, 1 bit: player whose turn it is.
REQ-013 SHALL have port hits_p1 / hits_p2, output, 5 bits each: accumulated hits scored by each player.
REQ-014 SHALL have port result_valid / result_hit, output, 1 bit each: one-cycle shot-result pulse and its outcome.
REQ-015 SHALL have port erro, output, 1 bit: sticky checker-timeout flag.
REQ-016 SHALL have port fim_jogo / vencedor, output, 1 bit each: game over and the winning player.

Function
REQ-017 SHALL implement FSM states IDLE, CHECK, RESOLVE, GAME_OVER, held in registers.
REQ-018 SHALL, in IDLE, drive shot_ready=1 and col_enable=0; shot_ready SHALL be 0 in every other state.
REQ-019 SHALL accept a shot on the edge where shot_valid=1 and shot_ready=1: latch shot_x/shot_y into col_x/col_y, clear hit_seen and the timeout counter, go to CHECK.
REQ-020 SHALL ignore shot_valid in all states other than IDLE, with no latching and no queuing.
REQ-021 SHALL, in CHECK, drive col_enable=1 and col_jogador=turno; col_x/col_y SHALL stay stable for the whole check.
REQ-022 SHALL set internal hit_seen on any CHECK cycle with col_hit=1; hit_seen is cleared only on shot acceptance.
REQ-023 SHALL leave CHECK for RESOLVE on the first edge with col_ready=1; if col_hit=1 on that same edge, it SHALL count as a hit.
REQ-024 SHALL increment the 6-bit timeout counter each CHECK cycle; at count == TIMEOUT without col_ready it SHALL set erro=1, treat the shot as a miss, and go to RESOLVE.
REQ-025 SHALL, in RESOLVE, last exactly one cycle with col_enable=0; this low cycle guarantees the checker's address reset before the next check.
REQ-026 SHALL, in RESOLVE, drive result_valid=1 and result_hit=hit_seen; result_valid SHALL be 0 in all other cycles.
REQ-027 SHALL, in RESOLVE on a hit, increment the shooter's counter (hits_p1 if turno=0, else hits_p2) at the RESOLVE→next edge.
REQ-028 SHALL go to GAME_OVER with vencedor=turno if the incremented counter equals TOTAL_PECAS; counters never exceed TOTAL_PECAS and SHALL NOT wrap.
REQ-029 SHALL otherwise return to IDLE: on a hit, turno is unchanged (the shooter fires again); on a miss or timeout, turno toggles.
REQ-030 SHALL, in GAME_OVER, hold fim_jogo=1, with vencedor, counters and turno frozen, and remain there until rst.
REQ-031 SHALL have a latency from shot acceptance to result_valid of N+2 cycles, where N is the number of CHECK cycles (N ≥ 1).

Reset
REQ-032 SHALL, on rst=1 at a clock edge, go to IDLE with turno=0, hits_p1=hits_p2=0, col_enable=0, col_x=col_y=0, col_jogador=0, result_valid=0, result_hit=0, erro=0, fim_jogo=0, vencedor=0.
REQ-033 SHALL, on rst asserted mid-CHECK, drop col_enable on that edge, produce no result pulse, and leave counters at 0.
REQ-034 SHALL give rst priority over every other input, including simultaneous shot_valid and col_ready.

Verification
REQ-035 SHALL be verified by: P1 shot (3,5), col_hit=1 at CHECK cycle 2, col_ready at cycle 4 -> result_valid pulse with result_hit=1, hits_p1=1, turno stays 0.
REQ-036 SHALL be verified by: P1 shot, col_ready=1 with col_hit=0 throughout -> result_hit=0, turno=1, hits unchanged, col_enable low for exactly 1 cycle before IDLE.
REQ-037 SHALL be verified by: col_ready never asserted -> RESOLVE after 31 CHECK cycles, erro=1, result_hit=0, turno toggles.
REQ-038 SHALL be verified by: hits_p2=16 and P2 hits -> hits_p2=17, fim_jogo=1, vencedor=1, further shot_valid ignored, shot_ready=0.
REQ-039 SHALL be verified by: rst pulsed in CHECK -> next cycle IDLE, col_enable=0, no result_valid, all outputs at reset values.
REQ-040 SHALL be verified by: shot_valid held high continuously -> exactly one acceptance per IDLE visit, with col_x/col_y unchanged during CHECK.
